mem_bus_arbiter: RTL and testbench

- Shares the single-port 8-bit system RAM between two requesters: the CPU (instruction/operand fetch, stack traffic) and the IO/DMA port.
- Sequences each RAM access through issue, fixed-latency wait and completion.
- Returns a one-cycle ready pulse, which the CPU controller consumes as its bus_ready.
- The CPU has priority; a starvation counter guarantees the IO port is eventually granted.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/arb_starve_ctr.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the system RAM bus arbiter.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive IO arbitration losses; sat_c forces an IO grant.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_c = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/IO arbiter for the single-port system RAM: issue, fixed-latency wait, one-cycle ready.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ready,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if ((RAM_LATENCY < 1) || (RAM_LATENCY > 15)) begin : g_bad_latency
    $error("mem_bus_arbiter: RAM_LATENCY must be in 1..15");
  end
  if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
    $error("mem_bus_arbiter: MAX_WAIT must be in 1..15");
  end

  arb_state_t        state_q, state_d;
  owner_t            own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ready_q, cpu_ready_d, io_ready_q, io_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, io_rdata_q, io_rdata_d;
  logic              busy_q, busy_d;
  logic              starve_sat_c, starve_inc_c, starve_clr_c, io_win_c;

  // IO only wins a contested cycle once it has lost MAX_WAIT times in a row.
  assign io_win_c     = io_req && (!cpu_req || starve_sat_c);
  assign starve_inc_c = (state_q == IDLE) && io_req && cpu_req && !io_win_c;
  assign starve_clr_c = (state_q == IDLE) && io_win_c;

  arb_starve_ctr #(
    .MAX (MAX_WAIT),
    .W   (CNT_W)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (starve_inc_c),
    .clr_i   (starve_clr_c),
    .sat_c   (starve_sat_c)
  );

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    cpu_ready_d = 1'b0;
    io_ready_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || io_req) begin
          own_d       = io_win_c ? OWN_IO : OWN_CPU;
          we_d        = io_win_c ? io_we : cpu_we;
          addr_d      = io_win_c ? io_addr : cpu_addr;
          wdata_d     = io_win_c ? io_wdata : cpu_wdata;
          // Bus strobes are registered so they appear exactly in the ISSUE cycle.
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = wdata_d;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = CNT_W'(RAM_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - CNT_W'(1);
        if (lat_q == CNT_W'(1)) begin
          if (!we_q) begin
            if (own_q == OWN_IO) io_rdata_d = mem_rdata;
            else                 cpu_rdata_d = mem_rdata;
          end
          if (own_q == OWN_IO) io_ready_d = 1'b1;
          else                 cpu_ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      own_q       <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      io_ready_q  <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      io_ready_q  <= io_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_ready  = io_ready_q;
  assign io_rdata  = io_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = own_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       io_req;
    logic       io_we;
    logic [7:0] io_addr;
    logic [7:0] io_wdata;
  } in_t;

  typedef struct packed {
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_ready;
    logic [7:0] cpu_rdata;
    logic       io_ready;
    logic [7:0] io_rdata;
    logic       busy;
    logic       owner;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       ram_load;
  logic       cpu_req, cpu_we, io_req, io_we;
  logic [7:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
  logic       cpu_ready, io_ready, mem_en, mem_we, busy, owner;
  logic [7:0] cpu_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;

  logic       cpu_req3, io_req3;
  logic [7:0] cpu_addr3;
  logic       cpu_ready3, io_ready3, mem_en3, mem_we3, busy3, owner3;
  logic [7:0] cpu_rdata3, io_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int   n_chk;
  int   n_err;
  vec_t vecs [16];

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LATENCY(2), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ready(io_ready), .io_rdata(io_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LATENCY(3), .MAX_WAIT(4)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req3), .cpu_we(1'b0), .cpu_addr(cpu_addr3), .cpu_wdata(8'h00),
    .cpu_ready(cpu_ready3), .cpu_rdata(cpu_rdata3),
    .io_req(io_req3), .io_we(1'b0), .io_addr(8'h00), .io_wdata(8'h00),
    .io_ready(io_ready3), .io_rdata(io_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: read data is valid only exactly RAM_LATENCY cycles after mem_en.
  logic [7:0] ram  [256];
  logic [7:0] pipe [2];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h4A;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    pipe[0] <= mem_en ? ram[mem_addr] : 8'hEE;
    pipe[1] <= pipe[0];
  end
  assign mem_rdata = pipe[1];

  logic [7:0] ram3  [256];
  logic [7:0] pipe3 [3];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram3[i] <= 8'(i) ^ 8'hA5;
    end else if (mem_en3 && mem_we3) begin
      ram3[mem_addr3] <= mem_wdata3;
    end
    pipe3[0] <= mem_en3 ? ram3[mem_addr3] : 8'hEE;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata3 = pipe3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o = {mem_en, mem_we, mem_addr, mem_wdata, cpu_ready, cpu_rdata,
         io_ready, io_rdata, busy, owner};
    return o;
  endfunction

  function automatic out_t mk(input logic me, input logic mw, input logic [7:0] ma,
                              input logic [7:0] md, input logic cr, input logic [7:0] crd,
                              input logic ir, input logic [7:0] ird, input logic b,
                              input logic ow);
    out_t o;
    o = {me, mw, ma, md, cr, crd, ir, ird, b, ow};
    return o;
  endfunction

  task automatic apply(input in_t v);
    {cpu_req, cpu_we, cpu_addr, cpu_wdata, io_req, io_we, io_addr, io_wdata} = v;
  endtask

  initial begin
    in_t  n_in, cr10, iw20, cr20;
    out_t o;
    int   k, rc, en_cnt, rdy_cnt, bad_cnt;
    logic [7:0] rd;
    logic       exp_io;
    int   exp3_cyc [3];
    logic [7:0] exp3_dat [3];

    n_chk = 0;
    n_err = 0;

    n_in = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    cr10 = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    iw20 = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hC3};
    cr20 = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    // CPU read 0x10 (RAM 0x5A), IO write 0x20=0xC3, CPU read-back of 0x20.
    vecs[0]  = '{cr10, mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0)};
    vecs[1]  = '{cr10, mk(1, 0, 8'h10, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0)};
    vecs[2]  = '{cr10, mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0)};
    vecs[3]  = '{cr10, mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0)};
    vecs[4]  = '{n_in, mk(0, 0, 8'h00, 8'h00, 1, 8'h5A, 0, 8'h00, 1, 0)};
    vecs[5]  = '{iw20, mk(0, 0, 8'h00, 8'h00, 0, 8'h5A, 0, 8'h00, 0, 0)};
    vecs[6]  = '{iw20, mk(1, 1, 8'h20, 8'hC3, 0, 8'h5A, 0, 8'h00, 1, 1)};
    vecs[7]  = '{iw20, mk(0, 0, 8'h00, 8'h00, 0, 8'h5A, 0, 8'h00, 1, 1)};
    vecs[8]  = '{iw20, mk(0, 0, 8'h00, 8'h00, 0, 8'h5A, 0, 8'h00, 1, 1)};
    vecs[9]  = '{cr20, mk(0, 0, 8'h00, 8'h00, 0, 8'h5A, 1, 8'h00, 1, 1)};
    vecs[10] = '{cr20, mk(0, 0, 8'h00, 8'h00, 0, 8'h5A, 0, 8'h00, 0, 1)};
    vecs[11] = '{cr20, mk(1, 0, 8'h20, 8'h00, 0, 8'h5A, 0, 8'h00, 1, 0)};
    vecs[12] = '{cr20, mk(0, 0, 8'h00, 8'h00, 0, 8'h5A, 0, 8'h00, 1, 0)};
    vecs[13] = '{cr20, mk(0, 0, 8'h00, 8'h00, 0, 8'h5A, 0, 8'h00, 1, 0)};
    vecs[14] = '{n_in, mk(0, 0, 8'h00, 8'h00, 1, 8'hC3, 0, 8'h00, 1, 0)};
    vecs[15] = '{n_in, mk(0, 0, 8'h00, 8'h00, 0, 8'hC3, 0, 8'h00, 0, 0)};

    reset_n   = 1'b0;
    ram_load  = 1'b1;
    apply(n_in);
    cpu_req3  = 1'b0;
    io_req3   = 1'b0;
    cpu_addr3 = 8'h00;
    repeat (3) tick();
    chk("reset_outputs", 64'(sample()), 64'(0));
    ram_load = 1'b0;
    reset_n  = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      o = sample();
      chk($sformatf("vec%0d", i), 64'(o), 64'(vecs[i].exp));
      apply(vecs[i].in);
      tick();
    end

    // Both requesters held: four CPU grants, then a forced IO grant, repeating.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 8'h30;
    k = 0;
    for (int c = 1; c <= 60 && k < 10; c++) begin
      tick();
      if (cpu_ready || io_ready) begin
        exp_io = ((k % 5) == 4);
        chk($sformatf("grant%0d_ready", k), 64'({io_ready, cpu_ready}),
            64'(exp_io ? 2'b10 : 2'b01));
        chk($sformatf("grant%0d_owner", k), 64'(owner), 64'(exp_io));
        chk($sformatf("grant%0d_cycle", k), 64'(c), 64'(4 + 5 * k));
        chk($sformatf("grant%0d_rdata", k), 64'(exp_io ? io_rdata : cpu_rdata),
            64'(exp_io ? 8'h7A : 8'h5A));
        k++;
        if (k == 10) begin
          cpu_req = 1'b0;
          io_req  = 1'b0;
        end
      end
    end
    chk("grant_count", 64'(k), 64'(10));
    tick();

    // Reset asserted mid-WAIT of an IO read: outputs clear without a clock edge.
    io_req = 1'b1; io_we = 1'b0; io_addr = 8'h30;
    tick();
    tick();
    chk("pre_reset_busy", 64'({busy, owner}), 64'(2'b11));
    #2;
    reset_n = 1'b0;
    io_req  = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(sample()), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    bad_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (io_ready || cpu_ready || busy || mem_en) bad_cnt++;
    end
    chk("no_activity_after_reset", 64'(bad_cnt), 64'(0));
    chk("io_rdata_after_reset", 64'(io_rdata), 64'(0));

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    rc = -1;
    rd = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (cpu_ready && rc < 0) begin
        rc = c;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    chk("post_reset_cpu_cycle", 64'(rc), 64'(4));
    chk("post_reset_cpu_rdata", 64'(rd), 64'(8'h5A));

    // IO request withdrawn once latched: one access, one ready.
    io_req = 1'b1; io_we = 1'b0; io_addr = 8'h40;
    en_cnt = 0; rdy_cnt = 0; rc = -1; rd = 8'h00;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (mem_en) en_cnt++;
      if (io_ready) begin
        rdy_cnt++;
        rc = c;
        rd = io_rdata;
      end
      if (c == 1) io_req = 1'b0;
    end
    chk("withdraw_mem_en_count", 64'(en_cnt), 64'(1));
    chk("withdraw_ready_count", 64'(rdy_cnt), 64'(1));
    chk("withdraw_ready_cycle", 64'(rc), 64'(4));
    chk("withdraw_io_rdata", 64'(rd), 64'(8'h0A));

    // RAM_LATENCY = 3, back-to-back CPU reads: ready every six cycles.
    exp3_cyc[0] = 5;  exp3_dat[0] = 8'hA4;
    exp3_cyc[1] = 11; exp3_dat[1] = 8'hA7;
    exp3_cyc[2] = 17; exp3_dat[2] = 8'hA6;
    cpu_req3  = 1'b1;
    cpu_addr3 = 8'h01;
    k = 0;
    bad_cnt = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (io_ready3) bad_cnt++;
      if (cpu_ready3 && k < 3) begin
        chk($sformatf("lat3_read%0d_cycle", k), 64'(c), 64'(exp3_cyc[k]));
        chk($sformatf("lat3_read%0d_rdata", k), 64'(cpu_rdata3), 64'(exp3_dat[k]));
        k++;
        if (k < 3) cpu_addr3 = 8'(k + 1);
        else       cpu_req3  = 1'b0;
      end
    end
    chk("lat3_read_count", 64'(k), 64'(3));
    chk("lat3_no_io_ready", 64'(bad_cnt), 64'(0));
    chk("lat3_idle_state", 64'({busy3, owner3, io_rdata3}), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
